// File: rtl/pic_inta_sequencer.sv
// 8259-style INTA sequencer: INT pin, two-pulse acknowledge, vector drive and ISR set/clear strobes.
// Optional auto-EOI on DONE is compiled in with `define PIC_AEOI_EN.
module pic_inta_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic [2:0] req_index,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic [7:0] isr_reg,
    input  logic [2:0] prio_base,
    input  logic       eoi_cmd,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       aeoi,
    output logic       int_out,
    output logic       freeze,
    output logic       isr_set,
    output logic       irr_clr,
    output logic [2:0] set_index,
    output logic       isr_clr,
    output logic [2:0] clr_index,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ACK1, S_WAIT2, S_ACK2, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       take_d;
    logic       inta_prev_q;
    logic       int_out_q, freeze_q, isr_set_q, data_oe_q;
    logic       isr_clr_q;
    logic [2:0] clr_index_q;
    logic       pend_q;
    logic [2:0] pend_idx_q;
    logic       inta_fall, inta_rise;
    logic       eoi_hit;
    logic [2:0] eoi_idx;
    logic       aeoi_fire;

    assign inta_fall = !inta_n && inta_prev_q;
    assign inta_rise = inta_n && !inta_prev_q;

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        spur_d  = spur_q;
        take_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (int_req) state_d = S_REQ;
            S_REQ: begin
                if (inta_fall) begin
                    state_d = S_ACK1;
                    // Request vanished right at the first INTA: answer with IR7 as a spurious vector.
                    if (int_req) begin
                        lvl_d  = req_index;
                        spur_d = 1'b0;
                        take_d = 1'b1;
                    end else begin
                        lvl_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end else if (!int_req) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK1:  if (inta_rise) state_d = S_WAIT2;
            S_WAIT2: if (inta_fall) state_d = S_ACK2;
            S_ACK2:  if (inta_rise) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Non-specific EOI clears the highest-priority in-service level, scanning upward from prio_base.
    always_comb begin
        logic [2:0] cand;
        eoi_hit = 1'b0;
        eoi_idx = 3'd0;
        cand    = 3'd0;
        if (eoi_specific) begin
            eoi_hit = 1'b1;
            eoi_idx = eoi_level;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                cand = prio_base + 3'(i);
                if (isr_reg[cand]) begin
                    eoi_hit = 1'b1;
                    eoi_idx = cand;
                end
            end
        end
    end

`ifdef PIC_AEOI_EN
    assign aeoi_fire = aeoi && (state_d == S_DONE) && (state_q == S_ACK2) && !spur_q;
`else
    logic unused_aeoi;
    assign unused_aeoi = aeoi;
    assign aeoi_fire   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lvl_q       <= 3'd0;
            spur_q      <= 1'b0;
            inta_prev_q <= 1'b0;
            int_out_q   <= 1'b0;
            freeze_q    <= 1'b0;
            isr_set_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            isr_clr_q   <= 1'b0;
            clr_index_q <= 3'd0;
            pend_q      <= 1'b0;
            pend_idx_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            spur_q      <= spur_d;
            inta_prev_q <= inta_n;
            int_out_q   <= (state_d == S_REQ) || (state_d == S_ACK1) || (state_d == S_WAIT2);
            freeze_q    <= (state_d == S_ACK1) || (state_d == S_WAIT2) ||
                           (state_d == S_ACK2) || (state_d == S_DONE);
            isr_set_q   <= take_d;
            data_oe_q   <= (state_d == S_ACK2);
            pend_q      <= 1'b0;
            if (aeoi_fire) begin
                // Auto-EOI owns the clear strobe this cycle; a coincident EOI write goes out next cycle.
                isr_clr_q   <= 1'b1;
                clr_index_q <= lvl_q;
                pend_q      <= eoi_cmd && eoi_hit;
                pend_idx_q  <= eoi_idx;
            end else if (pend_q) begin
                isr_clr_q   <= 1'b1;
                clr_index_q <= pend_idx_q;
            end else if (eoi_cmd && eoi_hit) begin
                isr_clr_q   <= 1'b1;
                clr_index_q <= eoi_idx;
            end else begin
                isr_clr_q   <= 1'b0;
            end
        end
    end

    assign int_out   = int_out_q;
    assign freeze    = freeze_q;
    assign isr_set   = isr_set_q;
    assign irr_clr   = isr_set_q;
    assign set_index = lvl_q;
    assign isr_clr   = isr_clr_q;
    assign clr_index = clr_index_q;
    assign data_oe   = data_oe_q;
    assign data_out  = data_oe_q ? {vector_base, lvl_q} : 8'h00;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: acknowledge cycles, spurious vector, EOI scan, reset, auto-EOI.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic [2:0] req_index;
    logic       inta_n;
    logic [4:0] vector_base;
    logic [7:0] isr_reg;
    logic [2:0] prio_base;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       aeoi;
    logic       int_out, freeze, isr_set, irr_clr, isr_clr, data_oe;
    logic [2:0] set_index, clr_index;
    logic [7:0] data_out;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .clk(clk), .rst(rst), .int_req(int_req), .req_index(req_index), .inta_n(inta_n),
        .vector_base(vector_base), .isr_reg(isr_reg), .prio_base(prio_base),
        .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level), .aeoi(aeoi),
        .int_out(int_out), .freeze(freeze), .isr_set(isr_set), .irr_clr(irr_clr),
        .set_index(set_index), .isr_clr(isr_clr), .clr_index(clr_index),
        .data_out(data_out), .data_oe(data_oe)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; int_req = 1'b0; req_index = 3'd0; inta_n = 1'b1;
        vector_base = 5'h08; isr_reg = 8'h00; prio_base = 3'd0;
        eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; aeoi = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        $display("-- reset state");
        chk("rst_int_out", {7'd0, int_out}, 8'd0);
        chk("rst_freeze",  {7'd0, freeze},  8'd0);
        chk("rst_isr_set", {7'd0, isr_set}, 8'd0);
        chk("rst_isr_clr", {7'd0, isr_clr}, 8'd0);
        chk("rst_data_oe", {7'd0, data_oe}, 8'd0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_set_index", {5'd0, set_index}, 8'd0);
        rst = 1'b0;
        tick();

        $display("-- acknowledge IR3, base 0x08, with coincident specific EOI");
        int_req = 1'b1; req_index = 3'd3;
        tick();
        chk("req_int_out", {7'd0, int_out}, 8'd1);
        chk("req_freeze",  {7'd0, freeze},  8'd0);
        inta_n = 1'b0; eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1;
        tick();
        eoi_cmd = 1'b0;
        chk("ack1_isr_set", {7'd0, isr_set}, 8'd1);
        chk("ack1_irr_clr", {7'd0, irr_clr}, 8'd1);
        chk("ack1_set_index", {5'd0, set_index}, 8'd3);
        chk("ack1_isr_clr", {7'd0, isr_clr}, 8'd1);
        chk("ack1_clr_index", {5'd0, clr_index}, 8'd1);
        chk("ack1_freeze", {7'd0, freeze}, 8'd1);
        chk("ack1_data_oe", {7'd0, data_oe}, 8'd0);
        tick();
        chk("ack1_set_once", {7'd0, isr_set}, 8'd0);
        chk("ack1_clr_once", {7'd0, isr_clr}, 8'd0);
        inta_n = 1'b1;
        tick();
        chk("wait2_int_out", {7'd0, int_out}, 8'd1);
        int_req = 1'b0;
        inta_n = 1'b0;
        tick();
        chk("ack2_int_out", {7'd0, int_out}, 8'd0);
        chk("ack2_data_oe", {7'd0, data_oe}, 8'd1);
        chk("ack2_vector",  data_out, 8'h43);
        inta_n = 1'b1;
        tick();
        chk("done_data_oe", {7'd0, data_oe}, 8'd0);
        chk("done_data_out", data_out, 8'h00);
        chk("done_freeze", {7'd0, freeze}, 8'd1);
        chk("done_isr_clr", {7'd0, isr_clr}, 8'd0);
        tick();
        chk("idle_freeze", {7'd0, freeze}, 8'd0);

        $display("-- spurious acknowledge (int_req drops at first INTA)");
        int_req = 1'b1; req_index = 3'd5;
        tick();
        int_req = 1'b0; inta_n = 1'b0;
        tick();
        chk("spur_isr_set", {7'd0, isr_set}, 8'd0);
        chk("spur_freeze",  {7'd0, freeze},  8'd1);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("spur_vector", data_out, 8'h47);
        inta_n = 1'b1; tick();
        tick();

        $display("-- request withdrawn in REQ");
        int_req = 1'b1; tick();
        int_req = 1'b0; tick();
        chk("withdraw_int_out", {7'd0, int_out}, 8'd0);

        $display("-- non-specific EOI scans");
        eoi_specific = 1'b0; isr_reg = 8'b0001_0100; prio_base = 3'd3; eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        chk("nseoi_p3_clr", {7'd0, isr_clr}, 8'd1);
        chk("nseoi_p3_idx", {5'd0, clr_index}, 8'd4);
        tick();
        chk("nseoi_pulse_once", {7'd0, isr_clr}, 8'd0);
        prio_base = 3'd5; eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        chk("nseoi_p5_idx", {5'd0, clr_index}, 8'd2);
        isr_reg = 8'b0100_0001; prio_base = 3'd7; eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        chk("nseoi_wrap_idx", {5'd0, clr_index}, 8'd0);
        isr_reg = 8'h00; eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        chk("nseoi_empty", {7'd0, isr_clr}, 8'd0);
        eoi_specific = 1'b1; eoi_level = 3'd6; eoi_cmd = 1'b1;
        tick();
        eoi_cmd = 1'b0;
        chk("seoi_clr", {7'd0, isr_clr}, 8'd1);
        chk("seoi_idx", {5'd0, clr_index}, 8'd6);
        tick();

        $display("-- INTA in IDLE ignored");
        inta_n = 1'b0; tick();
        chk("idle_inta_oe", {7'd0, data_oe}, 8'd0);
        chk("idle_inta_frz", {7'd0, freeze}, 8'd0);
        inta_n = 1'b1; tick();

        $display("-- reset in WAIT2");
        int_req = 1'b1; req_index = 3'd2; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        chk("w2_freeze", {7'd0, freeze}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw2_int_out", {7'd0, int_out}, 8'd0);
        chk("rstw2_freeze",  {7'd0, freeze},  8'd0);
        chk("rstw2_data_oe", {7'd0, data_oe}, 8'd0);
        int_req = 1'b0; inta_n = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_freeze", {7'd0, freeze}, 8'd0);
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("post_rst_oe", {7'd0, data_oe}, 8'd0);
        chk("post_rst_out", data_out, 8'h00);
        inta_n = 1'b1; tick();

        $display("-- auto-EOI acknowledge of IR6");
        aeoi = 1'b1; int_req = 1'b1; req_index = 3'd6; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; int_req = 1'b0; tick();
        inta_n = 1'b0; tick();
        chk("aeoi_vector", data_out, 8'h46);
        inta_n = 1'b1; eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        eoi_cmd = 1'b0;
`ifdef PIC_AEOI_EN
        chk("aeoi_clr", {7'd0, isr_clr}, 8'd1);
        chk("aeoi_idx", {5'd0, clr_index}, 8'd6);
        tick();
        chk("aeoi_defer_clr", {7'd0, isr_clr}, 8'd1);
        chk("aeoi_defer_idx", {5'd0, clr_index}, 8'd2);
        tick();
        chk("aeoi_defer_end", {7'd0, isr_clr}, 8'd0);
`else
        chk("noaeoi_clr", {7'd0, isr_clr}, 8'd1);
        chk("noaeoi_idx", {5'd0, clr_index}, 8'd2);
        tick();
        chk("noaeoi_end", {7'd0, isr_clr}, 8'd0);
`endif
        aeoi = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
PIC_INTA_SEQUENCER -- requirements
Module: pic_inta_sequencer

Interface
REQ-001 SHALL have port clk input 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-003 SHALL have port int_req input 1: level from priority resolver, high while a request outranks all in-service levels.
REQ-004 SHALL have port req_index input 3: winning IR level, valid while int_req high.
REQ-005 SHALL have port inta_n input 1: CPU interrupt acknowledge, active-low, already synchronous to clk.
REQ-006 SHALL have port vector_base input 5: ICW2 T7..T3.
REQ-007 SHALL have port isr_reg input 8: current ISR contents.
REQ-008 SHALL have port prio_base input 3: IR level holding highest priority.
REQ-009 SHALL have port eoi_cmd input 1: one-cycle pulse when OCW2 EOI is written.
REQ-010 SHALL have port eoi_specific input 1, eoi_level input 3: specific-EOI select and level, sampled with eoi_cmd.
REQ-011 SHALL have port aeoi input 1: ICW4 auto-EOI mode.
REQ-012 SHALL have port int_out output 1: INT pin to CPU.
REQ-013 SHALL have port freeze output 1: holds resolver inputs during acknowledge.
REQ-014 SHALL have port isr_set output 1, irr_clr output 1, set_index output 3: one-cycle set-ISR/clear-IRR strobes and level.
REQ-015 SHALL have port isr_clr output 1, clr_index output 3: one-cycle clear-ISR strobe and level.
REQ-016 SHALL have port data_out output 8, data_oe output 1: vector byte and bus drive enable.

Function
REQ-017 SHALL detect INTA falling edge as inta_n=0 with registered previous inta_n=1; rising edge symmetrically.
REQ-018 SHALL implement states IDLE, REQ, ACK1, WAIT2, ACK2, DONE.
REQ-019 IDLE: int_req=1 -> REQ next cycle; int_out=1 in REQ, WAIT2, ACK1.
REQ-020 REQ: INTA fall -> ACK1; latch req_index into lvl and spurious=0, or spurious=1 with lvl=7 if int_req=0 at that edge; int_req drop without INTA -> IDLE, int_out low next cycle.
REQ-021 On REQ->ACK1 transition with spurious=0, SHALL pulse isr_set and irr_clr for one cycle with set_index=lvl; spurious SHALL not pulse them.
REQ-022 freeze SHALL be 1 in ACK1, WAIT2, ACK2, DONE.
REQ-023 ACK1: INTA rise -> WAIT2; WAIT2: INTA fall -> ACK2.
REQ-024 ACK2: data_out={vector_base,lvl}, data_oe=1 while inta_n=0; INTA rise -> DONE, data_oe=0 same cycle as transition register update.
REQ-025 DONE: one cycle, then IDLE; int_out=0 in DONE and ACK2.
REQ-026 eoi_cmd with eoi_specific=1 SHALL pulse isr_clr next cycle with clr_index=eoi_level, regardless of isr_reg.
REQ-027 eoi_cmd with eoi_specific=0 SHALL clear first set isr_reg bit scanning prio_base, prio_base+1, ... mod 8 (3-bit wrap); isr_reg=0 -> no pulse.
REQ-028 eoi_cmd coincident with isr_set SHALL evaluate against pre-set isr_reg; both strobes fire in the same cycle.
REQ-029 INTA edges in IDLE SHALL be ignored; data_oe stays 0.
REQ-030 When data_oe=0, data_out SHALL be 8'h00.

Reset
REQ-031 rst=1 SHALL force IDLE and all outputs 0 (int_out, freeze, strobes, indices, data_out, data_oe), lvl=0, spurious=0, immediately and mid-sequence.
REQ-032 First cycle after rst release SHALL be IDLE, no edge detected even if inta_n=0 (previous-inta register resets to 0).

Configuration
REQ-033 With PIC_AEOI_EN defined and aeoi=1, DONE SHALL pulse isr_clr with clr_index=lvl unless spurious; an eoi_cmd in the same cycle SHALL be deferred one cycle.
REQ-034 Without PIC_AEOI_EN, aeoi SHALL be ignored and ISR cleared only by eoi_cmd.

Verification
REQ-035 vector_base=5'h08, int_req=1 index 3, two INTA pulses -> int_out high, isr_set/irr_clr index 3 once, data_out=8'h43 during second INTA.
REQ-036 int_req drops before first INTA fall, INTA pair -> no isr_set, data_out=8'h47.
REQ-037 isr_reg=8'b0001_0100, prio_base=3, non-specific EOI -> isr_clr index 4; prio_base=5 -> index 2.
REQ-038 rst asserted in WAIT2 -> int_out, freeze, data_oe 0 immediately; next INTA ignored.
REQ-039 PIC_AEOI_EN, aeoi=1, index 6 acknowledged -> isr_clr index 6 one cycle after second INTA rise.
